fmult_share_arbiter: RTL and testbench



---
 rtl/fmult_share_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fmult_share_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmult_share_arbiter.sv
// Round-robin share of one combinational FloatMult among NUM_REQ requesters; accept-to-resp_valid is 2 edges, 1 result/cycle.
// Backpressure: a stalled response holds stage B, which freezes stage A and drops req_ready to zero.
module FloatMult (
    input  logic [31:0] floatA,
    input  logic [31:0] floatB,
    output logic [31:0] floatProd
);
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] mprod;
    logic [9:0]  esum;
    logic [9:0]  efin;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        rnd;
    logic [23:0] mrnd;

    always_comb begin
        sign   = floatA[31] ^ floatB[31];
        ea     = floatA[30:23];
        eb     = floatB[30:23];
        mprod  = {24'd0, 1'b1, floatA[22:0]} * {24'd0, 1'b1, floatB[22:0]};
        esum   = {2'b00, ea} + {2'b00, eb} + {9'd0, mprod[47]} - 10'd127;
        mant   = mprod[47] ? mprod[46:24] : mprod[45:23];
        guard  = mprod[47] ? mprod[23] : mprod[22];
        sticky = mprod[47] ? (|mprod[22:0]) : (|mprod[21:0]);
        // Round to nearest, ties to even; a mantissa carry bumps the exponent.
        rnd    = guard & (sticky | mant[0]);
        mrnd   = {1'b0, mant} + {23'd0, rnd};
        efin   = esum + {9'd0, mrnd[23]};
        if (ea == 8'd0 || eb == 8'd0) begin
            floatProd = {sign, 31'd0};
        end else if (ea == 8'hFF || eb == 8'hFF) begin
            floatProd = {sign, 8'hFF, (ea == 8'hFF ? floatA[22:0] : 23'd0) | (eb == 8'hFF ? floatB[22:0] : 23'd0)};
        end else if (efin[9] || efin == 10'd0) begin
            floatProd = {sign, 31'd0};
        end else if (efin >= 10'd255) begin
            floatProd = {sign, 8'hFF, 23'd0};
        end else begin
            floatProd = {sign, efin[7:0], mrnd[22:0]};
        end
    end
endmodule

module fmult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [31:0]          resp_prod,
    output logic [CNT_W-1:0]     op_count
);
    logic              a_vld_q, a_vld_d;
    logic [31:0]       a_opa_q, a_opa_d;
    logic [31:0]       a_opb_q, a_opb_d;
    logic [ID_W-1:0]   a_id_q, a_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              b_vld_q, b_vld_d;
    logic [ID_W-1:0]   b_id_q, b_id_d;
    logic [31:0]       b_prod_q, b_prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              stall_b;
    logic              adv_a;
    logic              can_accept;
    logic              accept;
    logic              gnt_vld;
    int                gnt_int;
    logic [ID_W-1:0]   gnt_idx;
    logic [2*NUM_REQ-1:0] scan;
    logic [31:0]       mult_prod;

    FloatMult u_fmult (
        .floatA    (a_opa_q),
        .floatB    (a_opb_q),
        .floatProd (mult_prod)
    );

    // Rotate a doubled copy so bit 0 is the requester just after the pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_int = 0;
        scan    = {req_valid, req_valid} >> (int'(ptr_q) + 1);
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!gnt_vld && scan[0]) begin
                gnt_vld = 1'b1;
                gnt_int = (int'(ptr_q) + 1 + j) % NUM_REQ;
            end
            scan = scan >> 1;
        end
        gnt_idx = ID_W'(gnt_int);
    end

    assign stall_b    = b_vld_q & ~resp_ready;
    assign adv_a      = a_vld_q & ~stall_b;
    assign can_accept = ~a_vld_q | adv_a;
    assign accept     = can_accept & gnt_vld;
    assign req_ready  = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        a_vld_d  = a_vld_q;
        a_opa_d  = a_opa_q;
        a_opb_d  = a_opb_q;
        a_id_d   = a_id_q;
        ptr_d    = ptr_q;
        b_vld_d  = b_vld_q;
        b_id_d   = b_id_q;
        b_prod_d = b_prod_q;
        cnt_d    = cnt_q;
        if (accept) begin
            a_vld_d = 1'b1;
            a_opa_d = 32'(req_a >> (32 * gnt_int));
            a_opb_d = 32'(req_b >> (32 * gnt_int));
            a_id_d  = gnt_idx;
            ptr_d   = gnt_idx;
        end else if (adv_a) begin
            a_vld_d = 1'b0;
        end
        if (!stall_b) begin
            b_vld_d = a_vld_q;
            if (a_vld_q) begin
                b_prod_d = mult_prod;
                b_id_d   = a_id_q;
            end
        end
        if (b_vld_q && resp_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q  <= 1'b0;
            a_opa_q  <= '0;
            a_opb_q  <= '0;
            a_id_q   <= '0;
            ptr_q    <= ID_W'(NUM_REQ - 1);
            b_vld_q  <= 1'b0;
            b_id_q   <= '0;
            b_prod_q <= '0;
            cnt_q    <= '0;
        end else begin
            a_vld_q  <= a_vld_d;
            a_opa_q  <= a_opa_d;
            a_opb_q  <= a_opb_d;
            a_id_q   <= a_id_d;
            ptr_q    <= ptr_d;
            b_vld_q  <= b_vld_d;
            b_id_q   <= b_id_d;
            b_prod_q <= b_prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign resp_valid = b_vld_q;
    assign resp_id    = b_id_q;
    assign resp_prod  = b_prod_q;
    assign op_count   = cnt_q;
endmodule

// File: tb/tb_fmult_share_arbiter.sv
// Scoreboard bench for fmult_share_arbiter: grants, ordering, backpressure, special values, reset.
module tb_fmult_share_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IW-1:0]     resp_id;
    logic [31:0]       resp_prod;
    logic [CW-1:0]     op_count;

    fmult_share_arbiter #(.NUM_REQ(N), .ID_W(IW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int             total = 0;
    int             bad = 0;
    logic [31:0]    ta [8];
    logic [31:0]    tb_ [8];
    logic [31:0]    tp [8];
    logic [31:0]    cur_p [N];
    logic [IW+31:0] sbq [$];
    logic [CW-1:0]  exp_cnt;
    int             last_gnt;
    logic [N-1:0]   last_rdy;
    bit             auto_ops;
    int             cyc = 0;

    // One clock: drive operands at negedge, record handshakes before the edge, return just after it.
    task automatic cycle();
        logic [IW+31:0] e;
        @(negedge clk);
        if (auto_ops) begin
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = (i + cyc) % 8;
                req_a[i*32 +: 32] = ta[idx];
                req_b[i*32 +: 32] = tb_[idx];
                cur_p[i] = tp[idx];
            end
        end
        #1;
        last_gnt = -1;
        last_rdy = req_ready;
        if (!rst) begin
            total++;
            if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0)) begin
                bad++;
                $display("FAIL ready_onehot got=%b valid=%b", req_ready, req_valid);
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    last_gnt = i;
                    sbq.push_back({IW'(i), cur_p[i]});
                end
            end
            if (resp_valid && resp_ready) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got id=%0d prod=%h want=none", resp_id, resp_prod);
                end else begin
                    e = sbq.pop_front();
                    if ({resp_id, resp_prod} !== e) begin
                        bad++;
                        $display("FAIL sb_result got id=%0d prod=%h want id=%0d prod=%h",
                                 resp_id, resp_prod, e[IW+31:32], e[31:0]);
                    end
                end
                exp_cnt = exp_cnt + CW'(1);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sbq.delete();
            exp_cnt = '0;
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid  = '0;
        resp_ready = 1'b1;
        while (sbq.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d want=0", sbq.size());
        end
        cycle();
        cycle();
        total++;
        if (op_count !== exp_cnt) begin
            bad++;
            $display("FAIL op_count got=%0d want=%0d", op_count, exp_cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        auto_ops = 1'b1;
        resp_ready = 1'b1;
        do_reset();
        cycle();
        total++;
        if (resp_valid !== 1'b0 || resp_id !== '0 || resp_prod !== 32'd0 || op_count !== '0 || req_ready !== '0) begin
            bad++;
            $display("FAIL reset_state got vld=%b id=%0d prod=%h cnt=%0d rdy=%b want all zero",
                     resp_valid, resp_id, resp_prod, op_count, req_ready);
        end
    endtask

    task automatic test_single();
        auto_ops = 1'b0;
        req_a = '0;
        req_b = '0;
        req_a[31:0] = 32'h40800000;
        req_b[31:0] = 32'h40A00000;
        cur_p[0] = 32'h41A00000;
        req_valid = 4'b0001;
        cycle();
        total++;
        if (last_rdy !== 4'b0001) begin
            bad++;
            $display("FAIL single_ready got=%b want=0001", last_rdy);
        end
        req_valid = '0;
        cycle();
        total++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_prod !== 32'h41A00000) begin
            bad++;
            $display("FAIL single_resp got vld=%b id=%0d prod=%h want vld=1 id=0 prod=41a00000",
                     resp_valid, resp_id, resp_prod);
        end
        cycle();
        total++;
        if (op_count !== 16'd1) begin
            bad++;
            $display("FAIL single_count got=%0d want=1", op_count);
        end
        drain();
    endtask

    task automatic test_contention();
        auto_ops = 1'b1;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            total++;
            if (last_gnt != k % 4) begin
                bad++;
                $display("FAIL contention_grant step=%0d got=%0d want=%0d", k, last_gnt, k % 4);
            end
            if (k >= 1) begin
                total++;
                if (resp_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL contention_rate step=%0d got vld=%b want=1", k, resp_valid);
                end
            end
        end
        drain();
        total++;
        if (op_count !== 16'd8) begin
            bad++;
            $display("FAIL contention_count got=%0d want=8", op_count);
        end
    endtask

    task automatic test_fairness();
        int want [4];
        want = '{1, 3, 1, 3};
        auto_ops = 1'b1;
        do_reset();
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            total++;
            if (last_gnt != want[k]) begin
                bad++;
                $display("FAIL fairness_grant step=%0d got=%0d want=%0d", k, last_gnt, want[k]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back_stall();
        logic [IW-1:0] hold_id;
        logic [31:0]   hold_prod;
        auto_ops = 1'b1;
        resp_ready = 1'b1;
        req_valid = 4'b1111;
        cycle();
        cycle();
        hold_id = resp_id;
        hold_prod = resp_prod;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if (last_rdy !== '0 || resp_valid !== 1'b1 || resp_id !== hold_id || resp_prod !== hold_prod) begin
                bad++;
                $display("FAIL stall_hold step=%0d got rdy=%b vld=%b id=%0d prod=%h want rdy=0000 vld=1 id=%0d prod=%h",
                         k, last_rdy, resp_valid, resp_id, resp_prod, hold_id, hold_prod);
            end
        end
        total++;
        if (sbq.size() != 2) begin
            bad++;
            $display("FAIL stall_inflight got=%0d want=2", sbq.size());
        end
        drain();
    endtask

    task automatic test_special();
        auto_ops = 1'b0;
        req_a = '0;
        req_b = '0;
        req_a[2*32 +: 32] = 32'h35C0A3D7;
        req_b[2*32 +: 32] = 32'h00000000;
        cur_p[2] = 32'h00000000;
        req_a[1*32 +: 32] = 32'h3903126F;
        req_b[1*32 +: 32] = 32'h40000000;
        cur_p[1] = 32'h3983126F;
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b0010;
        cycle();
        total++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_prod !== 32'h00000000) begin
            bad++;
            $display("FAIL special_zero got vld=%b id=%0d prod=%h want vld=1 id=2 prod=00000000",
                     resp_valid, resp_id, resp_prod);
        end
        req_valid = '0;
        cycle();
        total++;
        if (resp_id !== 2'd1 || resp_prod !== 32'h3983126F) begin
            bad++;
            $display("FAIL special_small got id=%0d prod=%h want id=1 prod=3983126f", resp_id, resp_prod);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        auto_ops = 1'b1;
        resp_ready = 1'b1;
        req_valid = 4'b1111;
        cycle();
        cycle();
        resp_ready = 1'b0;
        do_reset();
        total++;
        if (resp_valid !== 1'b0 || op_count !== '0) begin
            bad++;
            $display("FAIL midreset_state got vld=%b cnt=%0d want vld=0 cnt=0", resp_valid, op_count);
        end
        resp_ready = 1'b1;
        req_valid = 4'b1001;
        cycle();
        total++;
        if (last_gnt != 0) begin
            bad++;
            $display("FAIL midreset_first got=%0d want=0", last_gnt);
        end
        cycle();
        total++;
        if (last_gnt != 3) begin
            bad++;
            $display("FAIL midreset_second got=%0d want=3", last_gnt);
        end
        drain();
    endtask

    initial begin
        ta  = '{32'h40800000, 32'h3FC00000, 32'h40400000, 32'h40000000,
                32'h3F000000, 32'h3F800000, 32'h40C00000, 32'hC0000000};
        tb_ = '{32'h40A00000, 32'h40000000, 32'h40400000, 32'h40000000,
                32'h41000000, 32'h40E00000, 32'h3FA00000, 32'h40400000};
        tp  = '{32'h41A00000, 32'h40400000, 32'h41100000, 32'h40800000,
                32'h40800000, 32'h40E00000, 32'h40F00000, 32'hC0C00000};
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;
        exp_cnt = '0;
        auto_ops = 1'b1;
        for (int i = 0; i < N; i++) cur_p[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_back_to_back_stall();
        test_special();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
